// File: rtl/fpmult_vrtl.sv
// rtl/fpmult_vrtl.sv - fixed-point shift-and-add multiplier with val/rdy handshake
// One multiplier bit per cycle. A signed multiplier MSB carries negative weight, so its partial product is subtracted.
module fpmult_vrtl #(
  parameter int n    = 32,
  parameter int d    = 16,
  parameter int sign = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         recv_val,
  output logic         recv_rdy,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         send_val,
  input  logic         send_rdy,
  output logic [n-1:0] c
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int CW = (n > 1) ? $clog2(n) : 1;
  localparam logic [CW-1:0] LAST = CW'(n - 1);

  state_t          r_state;
  logic            r_recv_rdy;
  logic            r_send_val;
  logic [2*n-1:0]  r_acc;
  logic [2*n-1:0]  r_mcand;
  logic [n-1:0]    r_mplier;
  logic [CW-1:0]   r_cnt;
  logic [n-1:0]    r_c;

  logic [2*n-1:0]  w_ext;
  logic [2*n-1:0]  w_pp;
  logic [2*n-1:0]  w_sum;
  logic            w_last;
  logic            w_sub;

  // The multiplicand is widened once at accept, so later shifts carry its sign into the upper half.
  assign w_ext  = (sign != 0) ? {{n{a[n-1]}}, a} : {{n{1'b0}}, a};
  assign w_pp   = r_mplier[0] ? r_mcand : '0;
  assign w_last = (r_cnt == LAST);
  assign w_sub  = (sign != 0) && w_last;
  assign w_sum  = w_sub ? (r_acc - w_pp) : (r_acc + w_pp);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_recv_rdy <= 1'b1;
      r_send_val <= 1'b0;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_cnt      <= '0;
      r_c        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (recv_val) begin
            r_mcand    <= w_ext;
            r_mplier   <= b;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_state    <= CALC;
            r_recv_rdy <= 1'b0;
          end
        end
        CALC: begin
          r_acc    <= w_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          if (w_last) begin
            r_c        <= w_sum[n+d-1:d];
            r_cnt      <= '0;
            r_state    <= DONE;
            r_send_val <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          if (send_rdy) begin
            r_state    <= IDLE;
            r_send_val <= 1'b0;
            r_recv_rdy <= 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_send_val <= 1'b0;
          r_recv_rdy <= 1'b1;
        end
      endcase
    end
  end

  assign recv_rdy = r_recv_rdy;
  assign send_val = r_send_val;
  assign c        = r_c;

endmodule

// File: tb/tb_fpmult_vrtl.sv
// tb/tb_fpmult_vrtl.sv - scoreboard bench for fpmult_vrtl, signed and unsigned instances
module tb_fpmult_vrtl;

  logic        clk = 1'b0;
  logic        reset;
  logic        recv_val, recv_rdy, send_val, send_rdy;
  logic [31:0] a, b, c;
  logic        u_recv_val, u_recv_rdy, u_send_val, u_send_rdy;
  logic [31:0] u_a, u_b, u_c;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  fpmult_vrtl #(.n(32), .d(16), .sign(1)) u_dut (
    .clk(clk), .reset(reset), .recv_val(recv_val), .recv_rdy(recv_rdy),
    .a(a), .b(b), .send_val(send_val), .send_rdy(send_rdy), .c(c)
  );

  fpmult_vrtl #(.n(32), .d(16), .sign(0)) u_dut_u (
    .clk(clk), .reset(reset), .recv_val(u_recv_val), .recv_rdy(u_recv_rdy),
    .a(u_a), .b(u_b), .send_val(u_send_val), .send_rdy(u_send_rdy), .c(u_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_s(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    p = 64'(longint'($signed(x)) * longint'($signed(y)));
    return p[47:16];
  endfunction

  function automatic logic [31:0] model_u(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    p = {32'b0, x} * {32'b0, y};
    return p[47:16];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request on the signed instance; bp>0 holds send_rdy low that many DONE cycles.
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v, input int bp);
    int cyc;
    logic [31:0] exp, c_hold;
    cyc = 0;
    while (!recv_rdy && cyc < 100) begin tick(); cyc++; end
    check("ready_before_op", {31'b0, recv_rdy}, 32'd1);
    a = ta; b = tb_v; recv_val = 1'b1;
    send_rdy = (bp == 0);
    tick();
    recv_val = 1'b0;
    sb_q.push_back(model_s(ta, tb_v));
    a = $urandom; b = $urandom;
    cyc = 0;
    while (!send_val && cyc < 200) begin
      if (cyc == 5) begin recv_val = 1'b1; a = $urandom; end
      tick();
      recv_val = 1'b0;
      cyc++;
    end
    check("latency", cyc, 32'd32);
    check("recv_rdy_done", {31'b0, recv_rdy}, 32'd0);
    exp = sb_q.pop_front();
    check("result", c, exp);
    c_hold = c;
    for (int i = 0; i < bp; i++) begin
      recv_val = i[0];
      tick();
      check("bp_send_val", {31'b0, send_val}, 32'd1);
      check("bp_recv_rdy", {31'b0, recv_rdy}, 32'd0);
      check("bp_c_stable", c, c_hold);
    end
    recv_val = 1'b0;
    send_rdy = 1'b1;
    tick();
    send_rdy = 1'b0;
    check("idle_send_val", {31'b0, send_val}, 32'd0);
    check("idle_recv_rdy", {31'b0, recv_rdy}, 32'd1);
    tick();
    check("no_queued_req", {31'b0, recv_rdy}, 32'd1);
    check("c_hold_idle", c, c_hold);
  endtask

  initial begin
    int cyc;
    logic [31:0] ra, rb;
    reset = 1'b1; recv_val = 1'b0; send_rdy = 1'b0; a = '0; b = '0;
    u_recv_val = 1'b0; u_send_rdy = 1'b0; u_a = '0; u_b = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_recv_rdy", {31'b0, recv_rdy}, 32'd1);
    check("rst_send_val", {31'b0, send_val}, 32'd0);
    check("rst_c", c, 32'h0);

    do_op(32'h00030000, 32'h00028000, 0);
    check("spec_3x2p5", c, 32'h00078000);
    do_op(32'hFFFE8000, 32'h00020000, 5);
    check("spec_neg", c, 32'hFFFD0000);
    do_op(32'h00000001, 32'h00000001, 0);
    check("spec_trunc_pos", c, 32'h00000000);
    do_op(32'hFFFFFFFF, 32'h00000001, 0);
    check("spec_trunc_floor", c, 32'hFFFFFFFF);
    do_op(32'h80000000, 32'h80000000, 0);
    do_op(32'h7FFFFFFF, 32'hFFFF0000, 1);
    for (int k = 0; k < 6; k++) begin
      ra = $urandom; rb = $urandom;
      do_op(ra, rb, k % 3);
    end

    // Reset mid-calculation aborts the operation without a result.
    a = 32'h00050000; b = 32'h00050000; recv_val = 1'b1;
    tick();
    recv_val = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_send_val", {31'b0, send_val}, 32'd0);
    check("abort_recv_rdy", {31'b0, recv_rdy}, 32'd1);
    check("abort_c", c, 32'h0);
    cyc = 0;
    while (!send_val && cyc < 40) begin tick(); cyc++; end
    check("abort_no_result", {31'b0, send_val}, 32'd0);
    do_op(32'h00030000, 32'h00028000, 0);
    check("after_abort", c, 32'h00078000);

    // Unsigned instance: wrap above bit n+d-1.
    u_a = 32'hFFFF0000; u_b = 32'h00020000; u_recv_val = 1'b1;
    tick();
    u_recv_val = 1'b0;
    sb_q.push_back(model_u(32'hFFFF0000, 32'h00020000));
    cyc = 0;
    while (!u_send_val && cyc < 200) begin tick(); cyc++; end
    check("u_latency", cyc, 32'd32);
    check("u_wrap", u_c, sb_q.pop_front());
    check("u_spec", u_c, 32'hFFFE0000);
    u_send_rdy = 1'b1;
    tick();
    u_send_rdy = 1'b0;
    check("u_idle", {31'b0, u_recv_rdy}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
